// File: rtl/motor_drive_ramped.sv
// Two-channel ramped H-bridge driver: mixes speed/turn, slew-limits each wheel,
// and coasts through a dead-time on every direction reversal.

module motor_drive_lane #(
  parameter int PWM_BITS    = 8,
  parameter int CMD_BITS    = 9,
  parameter int RAMP_STEP   = 4,
  parameter int DEAD_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       drive,
  input  logic                       tick,
  input  logic                       wrap,
  input  logic [PWM_BITS-1:0]        pwm_cnt,
  input  logic [PWM_BITS-1:0]        offset,
  input  logic signed [CMD_BITS:0]   raw,
  output logic [PWM_BITS-1:0]        speed,
  output logic                       en,
  output logic                       ina,
  output logic                       inb,
  output logic                       dead
);
  localparam int MAG_MAX = 2**PWM_BITS - 1;
  localparam int DW      = $clog2(DEAD_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  logic [PWM_BITS-1:0] cur_mag, mag_nxt, tgt_mag, duty;
  logic                cur_dir, dir_nxt, tgt_dir, en_raw;
  logic [0:0]          state, st_nxt;
  logic [DW-1:0]       dcnt, dcnt_nxt;
  logic signed [31:0]  raw_i, abs_i;
  logic [PWM_BITS:0]   sum;

  always_comb begin
    raw_i   = {{(32-CMD_BITS-1){raw[CMD_BITS]}}, raw};
    abs_i   = raw[CMD_BITS] ? -raw_i : raw_i;
    tgt_dir = ~raw[CMD_BITS];
    tgt_mag = (abs_i > MAG_MAX) ? PWM_BITS'(MAG_MAX) : abs_i[PWM_BITS-1:0];
  end

  always_comb begin
    mag_nxt  = cur_mag;
    dir_nxt  = cur_dir;
    st_nxt   = state;
    dcnt_nxt = dcnt;
    if (!enable) begin
      mag_nxt  = '0;
      st_nxt   = ST_RUN;
      dcnt_nxt = '0;
    end else if (state == ST_DEAD) begin
      if (dcnt == DW'(1)) begin
        st_nxt   = ST_RUN;
        dir_nxt  = ~cur_dir;
        dcnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt - DW'(1);
      end
    end else if (tick) begin
      // a zero target slews down in place and never flips direction
      if (tgt_mag == '0 || tgt_dir == cur_dir) begin
        if (tgt_mag > cur_mag)
          mag_nxt = (tgt_mag - cur_mag > STEP) ? cur_mag + STEP : tgt_mag;
        else if (tgt_mag < cur_mag)
          mag_nxt = (cur_mag - tgt_mag > STEP) ? cur_mag - STEP : tgt_mag;
      end else if (cur_mag != '0) begin
        mag_nxt = (cur_mag > STEP) ? cur_mag - STEP : '0;
      end else begin
        st_nxt   = ST_DEAD;
        dcnt_nxt = DW'(DEAD_CYCLES);
      end
    end
  end

  always_comb begin
    sum  = {1'b0, cur_mag} + {1'b0, offset};
    duty = (cur_mag == '0) ? '0 : (sum[PWM_BITS] ? '1 : sum[PWM_BITS-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mag <= '0;
      cur_dir <= 1'b1;
      state   <= ST_RUN;
      dcnt    <= '0;
      speed   <= '0;
      en_raw  <= 1'b0;
    end else begin
      cur_mag <= mag_nxt;
      cur_dir <= dir_nxt;
      state   <= st_nxt;
      dcnt    <= dcnt_nxt;
      if (wrap) speed <= enable ? duty : '0;
      en_raw  <= (pwm_cnt < speed);
    end
  end

  // pins come only from registers; drive is cleared by reset so pins go low at once
  logic run;
  assign run  = drive & (state == ST_RUN);
  assign en   = run & en_raw;
  assign ina  = run & cur_dir;
  assign inb  = run & ~cur_dir;
  assign dead = (state == ST_DEAD);
endmodule

module motor_drive_ramped #(
  parameter int PWM_BITS    = 8,
  parameter int CMD_BITS    = 9,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_DIV    = 1024,
  parameter int DEAD_CYCLES = 256
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       enable_in,
  input  logic [PWM_BITS-1:0]        offset_in,
  input  logic signed [CMD_BITS-1:0] speed_in,
  input  logic signed [CMD_BITS-1:0] turn_in,
  output logic [5:0]                 motor_out,
  output logic [PWM_BITS-1:0]        speed_1,
  output logic [PWM_BITS-1:0]        speed_2,
  output logic [1:0]                 dead_out
);
  localparam int NUM_LANES = 2;
  localparam int PW        = $clog2(RAMP_DIV);

  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick, wrap, drive;
  logic signed [CMD_BITS-1:0] half;

  logic [NUM_LANES-1:0][CMD_BITS:0]   raw;
  logic [NUM_LANES-1:0][PWM_BITS-1:0] speed;
  logic [NUM_LANES-1:0]               en, ina, inb, dead;

  assign tick = enable_in && (presc == PW'(RAMP_DIV - 1));
  assign wrap = &pwm_cnt;
  assign half = turn_in >>> 1;
  assign raw[0] = {speed_in[CMD_BITS-1], speed_in} - {half[CMD_BITS-1], half};
  assign raw[1] = {speed_in[CMD_BITS-1], speed_in} + {half[CMD_BITS-1], half};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc   <= '0;
      pwm_cnt <= '0;
      drive   <= 1'b0;
    end else begin
      presc   <= (!enable_in || tick) ? '0 : presc + PW'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      drive   <= enable_in;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    motor_drive_lane #(
      .PWM_BITS(PWM_BITS), .CMD_BITS(CMD_BITS),
      .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_lane (
      .clk(clk_in), .rst_n(rst_n_in), .enable(enable_in), .drive(drive),
      .tick(tick), .wrap(wrap), .pwm_cnt(pwm_cnt), .offset(offset_in),
      .raw(raw[i]), .speed(speed[i]), .en(en[i]), .ina(ina[i]),
      .inb(inb[i]), .dead(dead[i])
    );
  end

  assign motor_out = {en[0], ina[0], inb[0], ina[1], inb[1], en[1]};
  assign speed_1   = speed[0];
  assign speed_2   = speed[1];
  assign dead_out  = dead;
endmodule

// File: doc/motor_drive_ramped.md
# motor_drive_ramped

Parametrised successor to the two-channel differential motor driver. Mixes a signed speed/turn command into left/right wheel demands, slew-limits each channel toward its demand, and inserts a coast dead-time on every direction reversal. Drives the H-bridge enable (PWM) and direction pins. Sits between the chase controller and the motor pins.

## Interface
- PWM_BITS, 8, PWM counter and duty width.
- CMD_BITS, 9, width of the signed speed/turn commands.
- RAMP_STEP, 4, maximum magnitude change per ramp tick.
- RAMP_DIV, 1024, clock cycles per ramp tick (≥2).
- DEAD_CYCLES, 256, coast cycles between ramp-to-zero and reversed drive (≥1).

- clk_in, input, 1, system clock.
- rst_n_in, input, 1, reset; one clock; asynchronous, active-low.
- enable_in, input, 1, 0 = immediate coast, ramp state cleared.
- offset_in, input, PWM_BITS, minimum duty added to any nonzero magnitude.
- speed_in, input, CMD_BITS signed, forward command.
- turn_in, input, CMD_BITS signed, turn command.
- motor_out, output, 6, {en1, ina1, inb1, ina2, inb2, en2}.
- speed_1, speed_2, output, PWM_BITS, applied duty per channel.
- dead_out, output, 2, channel in DEAD state ({ch2, ch1}).

## Operation
- Mix (CMD_BITS+1 signed): raw1 = speed_in − (turn_in >>> 1); raw2 = speed_in + (turn_in >>> 1). Target dir = sign of raw (fwd if ≥0); target mag = |raw| saturated to 2^PWM_BITS − 1.
- Per channel registers: cur_mag (PWM_BITS), cur_dir (1 = fwd), state ∈ {RUN, DEAD}, dead counter.
- Prescaler counts 0..RAMP_DIV−1; tick asserted for one cycle at RAMP_DIV−1.
- RUN, on tick:
  - target mag = 0, or target dir == cur_dir: move cur_mag toward target mag by min(RAMP_STEP, |difference|). Zero target never changes cur_dir.
  - target dir ≠ cur_dir, cur_mag > 0: decrease cur_mag by min(RAMP_STEP, cur_mag).
  - target dir ≠ cur_dir, cur_mag = 0: go to DEAD, load dead counter with DEAD_CYCLES.
- DEAD: ina = inb = 0, en = 0; counter decrements every cycle; at 1, cur_dir ← ¬cur_dir, back to RUN (cur_mag stays 0). Target changes during DEAD are ignored until RUN.
- Duty: cur_mag = 0 → 0; otherwise min(cur_mag + offset_in, 2^PWM_BITS − 1) (no wrap).
- PWM: free-running PWM_BITS counter shared by both channels; duty latched into speed_x only when counter = all-ones; en_x = (counter < speed_x). Duty 0 → en always 0; max duty → one low cycle per period.
- Direction pins in RUN: ina = cur_dir, inb = ¬cur_dir (driven even at duty 0).
- enable_in = 0: synchronously cur_mag ← 0, state ← RUN, cur_dir held, prescaler ← 0, all six motor_out bits 0, speed_x latched to 0 at next wrap. Re-enable resumes ramp from 0.

## Timing
- Reset (async, rst_n_in low): cur_mag 0, cur_dir fwd, RUN, prescaler 0, PWM counter 0, speed_1/2 = 0, dead_out = 0, motor_out = 6'b000000 (direction pins forced 0 while reset asserted). First cycle after release: motor_out = 6'b010100.
- Reset mid-ramp or mid-DEAD: all state cleared immediately, no glitch pulses.
- Command to first magnitude change: ≤ RAMP_DIV cycles; to speed_x update: additional ≤ 2^PWM_BITS cycles.
- Full reversal from magnitude M: ceil(M/RAMP_STEP) ticks down, 1 tick to enter DEAD, DEAD_CYCLES coast, then ramp up.
- Channels are independent; both may be in DEAD simultaneously.
- en_x registered; no combinational path from inputs to motor_out.

## Test plan
Bench parameters: PWM_BITS=8, RAMP_STEP=4, RAMP_DIV=4, DEAD_CYCLES=8, offset_in=0 unless stated.
- Ramp: enable, speed_in=100, turn_in=0 -> cur_mag +4 per 4 cycles, reaches 100 after 25 ticks; speed_1=speed_2=100 at next PWM wrap; en high 100 of 256 cycles; ina=1, inb=0.
- Reversal: from steady 100, speed_in=−100 -> ramp to 0 in 25 ticks, DEAD 8 cycles with ina=inb=en=0 and dead_out=2'b11, then ina=0, inb=1, ramp to 100.
- Saturation/mix: speed_in=255, turn_in=−256 -> ch1 target 255 (raw 383), ch2 target 127; offset_in=50 with cur_mag 220 -> speed = 255, not 14.
- Zero target: steady 40 fwd, speed_in=0 -> ramps to 0, cur_dir stays fwd, no DEAD entry; speed_x=0, en stuck low despite offset_in=50.
- Enable drop: mid-ramp at 60, enable_in=0 -> motor_out=0 next cycle, speed_x=0 after wrap; re-enable restarts from 0.
- Async reset mid-DEAD: rst_n_in low between clock edges -> motor_out=0 immediately, dead_out=0; after release ramp restarts fwd from 0.
